// File: rtl/mmio_decoder_if.sv
// CPU data-port and RAM-port signal bundle for mmio_decoder.
// master = CPU/RAM side (drives requests and RAM read data), slave = decoder.
interface mmio_decoder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mmio_decoder.sv
// RAM / I-O register decoder; RAM reads complete MEM_LAT cycles after accept, all else same cycle.
// Requests are held by the CPU until cpu_ready; optional button debounce under MMIO_DEBOUNCE_EN.
module mmio_decoder #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 0,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  mmio_decoder_if.slave bus,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic [15:0] sw,
  output logic [15:0] result
);
  typedef enum logic {S_IDLE, S_MEM_WAIT} state_e;

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [1:0]        btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [1:0]        btn_prev_q, btn_prev_d;
  logic [2:0]        status_q, status_d;
  logic [15:0]       evcnt_q, evcnt_d;
  logic [15:0]       result_q, result_d;
  logic [1:0]        db_lvl_q, db_lvl_d;
  logic [DB_W-1:0]   db_cnt_q [2];
  logic [DB_W-1:0]   db_cnt_d [2];

  logic              req_idle, io_sel, io_mapped, io_acc, io_wr;
  logic              ready;
  logic [1:0]        word;
  logic [1:0]        btn_cond, btn_rise;
  logic [DATA_W-1:0] rd_dat;

  assign io_sel    = bus.cpu_addr[ADDR_W-1];
  assign io_mapped = (bus.cpu_addr[ADDR_W-2:4] == '0);
  assign word      = bus.cpu_addr[3:2];
  assign req_idle  = bus.cpu_req & (state_q == S_IDLE) & ~reset;
  assign io_acc    = req_idle & io_sel;
  assign io_wr     = io_acc & bus.cpu_we;

  assign bus.mem_addr  = bus.cpu_addr;
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.mem_we    = req_idle & bus.cpu_we & ~io_sel;
  assign bus.cpu_ready = ready & ~reset;
  assign bus.cpu_rdata = (ready & ~reset) ? rd_dat : '0;
  assign result        = result_q;

  // Access FSM and read-data mux.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    rd_dat  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          if (io_sel) begin
            ready = 1'b1;
            if (!bus.cpu_we && io_mapped) begin
              unique case (word)
                2'd0:    rd_dat = DATA_W'(status_q);
                2'd1:    rd_dat = DATA_W'(sw_s2_q);
                2'd2:    rd_dat = DATA_W'(result_q);
                default: rd_dat = DATA_W'(evcnt_q);
              endcase
            end
          end else if (bus.cpu_we) begin
            ready = 1'b1;
          end else if (MEM_LAT == 0) begin
            ready  = 1'b1;
            rd_dat = bus.mem_rdata;
          end else begin
            state_d = S_MEM_WAIT;
            cnt_d   = CNT_W'(MEM_LAT - 1);
          end
        end
      end
      default: begin
        if (cnt_q == '0) begin
          ready   = 1'b1;
          rd_dat  = bus.mem_rdata;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // Input conditioning, event latching and I/O register updates.
  always_comb begin
    sw_s1_d  = sw;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = {btn_r, btn_l};
    btn_s2_d = btn_s1_q;
    db_lvl_d = db_lvl_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
    end
`ifdef MMIO_DEBOUNCE_EN
    // Level flips only after DEBOUNCE_CYC consecutive mismatching cycles.
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_lvl_d[i] = ~db_lvl_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
    btn_cond = db_lvl_q;
`else
    btn_cond = btn_s2_q;
`endif
    btn_prev_d = btn_cond;
    btn_rise   = btn_cond & ~btn_prev_q;

    status_d = status_q;
    result_d = result_q;
    if (io_wr && io_mapped && word == 2'd0) begin
      status_d = status_q & ~bus.cpu_wdata[2:0];
    end
    if (io_wr && io_mapped && word == 2'd2) begin
      result_d = bus.cpu_wdata[15:0];
    end
    // Set after clear so a same-cycle event survives the W1C.
    status_d = status_d | {io_acc & ~io_mapped, btn_rise};
    evcnt_d  = evcnt_q + 16'(btn_rise[0]) + 16'(btn_rise[1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
      db_lvl_q   <= '0;
      db_cnt_q   <= '{default: '0};
      status_q   <= '0;
      evcnt_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
      db_lvl_q   <= db_lvl_d;
      db_cnt_q   <= db_cnt_d;
      status_q   <= status_d;
      evcnt_q    <= evcnt_d;
      result_q   <= result_d;
    end
  end
endmodule

// File: tb/tb_mmio_decoder.sv
// Directed bench for mmio_decoder with MEM_LAT = 3 and DEBOUNCE_CYC = 4.
module tb_mmio_decoder;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MEM_LAT = 3;
`ifdef MMIO_DEBOUNCE_EN
  localparam int DB = 4;
  localparam int EV_BASE = 1;
`else
  localparam int DB = 0;
  localparam int EV_BASE = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_l, btn_r;
  logic [15:0] sw;
  logic [15:0] result;
  int          n_chk = 0;
  int          n_fail = 0;

  mmio_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mmio_decoder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .btn_l(btn_l), .btn_r(btn_r), .sw(sw), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mem_we;
    logic [15:0] exp_result;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp, input string name);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    @(negedge clk);
    check({name, " ready"}, 32'(bus.cpu_ready), 32'd1);
    if (!we) check({name, " rdata"}, bus.cpu_rdata, exp);
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic mem_read(input logic [7:0] addr, input logic [31:0] data, input string name);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = addr; bus.mem_rdata = data;
    for (int c = 0; c <= MEM_LAT; c++) begin
      @(negedge clk);
      check($sformatf("%s ready c%0d", name, c), 32'(bus.cpu_ready), 32'(c == MEM_LAT));
      check($sformatf("%s mem_we c%0d", name, c), 32'(bus.mem_we), 32'd0);
      if (c == MEM_LAT) check({name, " rdata"}, bus.cpu_rdata, data);
      tick();
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check({name, " single pulse"}, 32'(bus.cpu_ready), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 8'h80, 32'h0,        32'h0,    1'b0, 16'h0};
    vecs[1]  = '{1'b0, 8'h88, 32'h0,        32'h0,    1'b0, 16'h0};
    vecs[2]  = '{1'b0, 8'h8C, 32'h0,        32'h0,    1'b0, 16'h0};
    vecs[3]  = '{1'b1, 8'h88, 32'h0001_2345, 32'h0,   1'b0, 16'h0};
    vecs[4]  = '{1'b0, 8'h88, 32'h0,        32'h2345, 1'b0, 16'h2345};
    vecs[5]  = '{1'b0, 8'h84, 32'h0,        32'hA5A5, 1'b0, 16'h2345};
    vecs[6]  = '{1'b1, 8'h10, 32'h1122_3344, 32'h0,   1'b1, 16'h2345};
    vecs[7]  = '{1'b1, 8'h8C, 32'h0000_FFFF, 32'h0,   1'b0, 16'h2345};
    vecs[8]  = '{1'b0, 8'h8C, 32'h0,        32'h0,    1'b0, 16'h2345};
    vecs[9]  = '{1'b0, 8'h90, 32'h0,        32'h0,    1'b0, 16'h2345};
    vecs[10] = '{1'b0, 8'h80, 32'h0,        32'h4,    1'b0, 16'h2345};
    vecs[11] = '{1'b1, 8'h80, 32'h4,        32'h0,    1'b0, 16'h2345};
    vecs[12] = '{1'b0, 8'h80, 32'h0,        32'h0,    1'b0, 16'h2345};
    vecs[13] = '{1'b1, 8'h98, 32'h0000_BEEF, 32'h0,   1'b0, 16'h2345};
    vecs[14] = '{1'b0, 8'h88, 32'h0,        32'h2345, 1'b0, 16'h2345};
    vecs[15] = '{1'b0, 8'h80, 32'h0,        32'h4,    1'b0, 16'h2345};

    reset = 1'b1; btn_l = 1'b0; btn_r = 1'b0; sw = 16'hA5A5;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.mem_rdata = 32'h5555_AAAA;
    tick(); tick();
    @(negedge clk);
    check("reset cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset result", 32'(result), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    check("idle no ready", 32'(bus.cpu_ready), 32'd0);
    tick();

    for (int i = 0; i < 16; i++) begin
      bus.cpu_req = 1'b1; bus.cpu_we = vecs[i].we;
      bus.cpu_addr = vecs[i].addr; bus.cpu_wdata = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 32'(bus.cpu_ready), 32'd1);
      check($sformatf("vec%0d rdata", i), bus.cpu_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_mem_we));
      check($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].exp_result));
      if (vecs[i].exp_mem_we) begin
        check($sformatf("vec%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
      end
      tick();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    end

    mem_read(8'h10, 32'hDEAD_BEEF, "ram rd");

    // Reset lands on the cycle the read would have completed.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h14; bus.mem_rdata = 32'hCAFE_F00D;
    for (int c = 0; c < MEM_LAT; c++) begin
      @(negedge clk);
      check($sformatf("abort wait c%0d", c), 32'(bus.cpu_ready), 32'd0);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort ready in reset", 32'(bus.cpu_ready), 32'd0);
    tick();
    reset = 1'b0; bus.cpu_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort post c%0d", c), 32'(bus.cpu_ready), 32'd0);
      tick();
    end
    check("result after reset", 32'(result), 32'd0);
    mem_read(8'h18, 32'h0BAD_F00D, "ram rd after abort");

`ifdef MMIO_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) begin
      btn_l = ((i % 4) < 2);
      tick();
    end
    btn_l = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    io_access(1'b0, 8'h80, 32'h0, 32'h1, "bounce status");
    io_access(1'b0, 8'h8C, 32'h0, 32'h1, "bounce evcnt");
    io_access(1'b1, 8'h80, 32'h1, 32'h0, "bounce w1c");
    io_access(1'b0, 8'h80, 32'h0, 32'h0, "bounce cleared");
    btn_l = 1'b0;
    for (int i = 0; i < 12; i++) tick();
`endif

    // Both buttons rise together; W1C lands on the cycle the bits get set.
    btn_l = 1'b1; btn_r = 1'b1;
    for (int i = 0; i < 1 + DB; i++) tick();
    io_access(1'b0, 8'h80, 32'h0, 32'h0, "both pre-set");
    io_access(1'b1, 8'h80, 32'h3, 32'h0, "both w1c race");
    io_access(1'b0, 8'h80, 32'h0, 32'h3, "both set wins");
    io_access(1'b0, 8'h8C, 32'h0, 32'(EV_BASE + 2), "both evcnt");
    io_access(1'b1, 8'h80, 32'h3, 32'h0, "both clear");
    io_access(1'b0, 8'h80, 32'h0, 32'h0, "both cleared");
    btn_l = 1'b0; btn_r = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    io_access(1'b0, 8'h8C, 32'h0, 32'(EV_BASE + 2), "release no event");
    io_access(1'b0, 8'h80, 32'h0, 32'h0, "release status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_decoder.md
# mmio_decoder

Parametrised memory-mapped bus decoder between the CPU data port and the data RAM plus an on-block I/O register file. It replaces the fixed one-bit RAM/I-O split with a request/ready handshake that tolerates multi-cycle RAM reads. It also provides button synchronisation with event latching, switch sampling, a result register for the display path, and an error flag for unmapped I/O accesses.

## Interface
Parameters:
- ADDR_W, 8, byte address width; `cpu_addr[ADDR_W-1]` = 1 selects I/O, 0 selects RAM
- DATA_W, 32, bus data width (≥16)
- MEM_LAT, 0, RAM read latency in cycles (0 = combinational `mem_rdata`)
- DEBOUNCE_CYC, 16, required stable cycles for button debounce (≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  reset; synchronous and active-high
- cpu_req  in  1  access request; held stable until `cpu_ready`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid only while `cpu_ready`, else 0
- cpu_ready  out  1  access completes this cycle
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address (= `cpu_addr`)
- mem_wdata  out  DATA_W  RAM write data (= `cpu_wdata`)
- mem_rdata  in  DATA_W  RAM read data
- btn_l, btn_r  in  1  asynchronous push buttons
- sw  in  16  asynchronous switches
- result  out  16  RESULT register, feeds the 7-seg path

## Operation
- I/O map, word offset = `cpu_addr[3:2]` with `cpu_addr[ADDR_W-2:4]` = 0:
  - 0 STATUS (R/W1C):
    - bit0 = L event
    - bit1 = R event
    - bit2 = unmapped-access error
  - 1 SW (R): 2-flop-synchronised `sw`, zero-extended
  - 2 RESULT (R/W): `cpu_wdata[15:0]`
  - 3 EVCNT (R): 16-bit count of all button events, wraps 0xFFFF→0; writes ignored
- Any I/O address with nonzero `cpu_addr[ADDR_W-2:4]` is unmapped:
  - reads return 0
  - writes are ignored
  - STATUS.bit2 is set
  - `cpu_ready` is still asserted
- `mem_we` = `cpu_req & cpu_we & ~cpu_addr[ADDR_W-1]`. It is never asserted for I/O addresses and never asserted in a MEM_WAIT cycle.
- FSM:
  - IDLE→MEM_WAIT on a RAM read request when MEM_LAT > 0. A latency counter loads MEM_LAT-1.
  - MEM_WAIT decrements the counter each cycle. When it reaches 0 it asserts `cpu_ready`, drives `cpu_rdata` = `mem_rdata`, and returns to IDLE.
  - All other requests complete in IDLE.
- Button event: a rising edge of the conditioned button level sets its STATUS bit (sticky) and increments EVCNT.
- Both buttons rising in the same cycle: both bits are set and EVCNT increments by 2.
- W1C: a STATUS write clears the bits where `cpu_wdata` = 1. Set wins over clear in the same cycle.

## Timing
- Reset values:
  - `cpu_ready` = 0, `cpu_rdata` = 0, `mem_we` = 0
  - `result` = 0, STATUS = 0, EVCNT = 0
  - synchronisers and debounced levels = 0
  - FSM = IDLE
- I/O read/write and RAM write: `cpu_ready` is combinational, in the same cycle as `cpu_req`. I/O registers update at that cycle's edge.
- RAM read, MEM_LAT = 0: ready in the same cycle. MEM_LAT = N: ready in exactly cycle N after the accept cycle. `mem_addr` is held throughout because `cpu_req`/`cpu_addr` are held.
- `cpu_req` low during MEM_WAIT is a protocol violation; the block still completes its count.
- Reset during MEM_WAIT: back to IDLE, no `cpu_ready` for the aborted access.
- RESULT write is visible on `result` the cycle after the write.
- Button synchroniser: 2 flops. Event latency is given in Configuration.

## Configuration
- Macro `MMIO_DEBOUNCE_EN`. When defined:
  - The debounced level toggles only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles. Any mismatch gap resets the counter.
  - The STATUS bit reads 1 at cycle DEBOUNCE_CYC+3 after the first sampled high.
  - Bounces shorter than DEBOUNCE_CYC produce no event.
- When not defined:
  - There is no counter; the conditioned level is the synchronised input.
  - The STATUS bit reads 1 at cycle 3.
  - Every synchronised rising edge is an event.

## Test plan
- Reset, then read 0x80/0x88/0x8C → 0, 0, 0. `result` = 0. `cpu_ready` is 0 while `cpu_req` = 0.
- MEM_LAT = 3: read 0x10 with `mem_rdata` = 0xDEADBEEF → `cpu_ready` pulses once, exactly 3 cycles after accept, with that data. Write 0x10 → `mem_we` = 1 and ready in the same cycle.
- Write 0x88 with 0x0001_2345 → `result` = 0x2345 next cycle. Read 0x88 → 0x2345. Read 0x84 with `sw` = 0xA5A5 (stable ≥3 cycles) → 0xA5A5.
- `MMIO_DEBOUNCE_EN`, DEBOUNCE_CYC = 4: `btn_l` toggles at 2-cycle intervals for 10 cycles, then holds high → one event total. STATUS = 0x1, EVCNT = 1. Write 0x80 with 0x1 → STATUS = 0.
- Both buttons high in the same cycle, with a W1C of 0x3 arriving the same cycle the bits set → STATUS = 0x3 (set wins), EVCNT = 2.
- Read 0x90 → data 0, ready, STATUS.bit2 = 1. Assert reset mid-MEM_WAIT → no `cpu_ready`, FSM in IDLE, next RAM read completes normally.
